// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready streaming, one B-bit block per stage.
// Define CSEL_ADDER_PIPE_SAT_EN to saturate the signed result on overflow.
module csel_adder_pipe #(
    parameter int N = 32,
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         carryin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carryout,
    output logic         overflow
);

    localparam int S = N / B;

    logic         vld  [S];
    logic [N-1:0] acc  [S];
    logic         cy   [S];
    logic [N-1:0] xs   [S];
    logic [N-1:0] ys   [S];
    logic         ovf;

    logic [B-1:0] sa   [S];
    logic [B-1:0] sb   [S];
    logic         scin [S];
    logic [B:0]   s0   [S];
    logic [B:0]   s1   [S];
    logic [B:0]   sel  [S];
    logic         sov  [S];
    logic [N-1:0] nacc [S];

    logic         adv;
    logic [N-1:0] yeff;

    assign adv       = !vld[S-1] || out_ready;
    assign in_ready  = adv;
    assign yeff      = sub ? ~y : y;
    assign out_valid = vld[S-1];
    assign carryout  = cy[S-1];
    assign overflow  = ovf;

    // Stage 0 slices straight from the inputs; later stages use the skewed operands
    // and the carry registered by the previous stage.
    always_comb begin
        for (int k = 0; k < S; k++) begin
            sa[k]   = '0;
            sb[k]   = '0;
            scin[k] = 1'b0;
            s0[k]   = '0;
            s1[k]   = '0;
            sel[k]  = '0;
            sov[k]  = 1'b0;
            nacc[k] = '0;
        end

        sa[0]   = x[B-1:0];
        sb[0]   = yeff[B-1:0];
        scin[0] = sub | carryin;
        for (int k = 1; k < S; k++) begin
            sa[k]   = xs[k-1][k*B +: B];
            sb[k]   = ys[k-1][k*B +: B];
            scin[k] = cy[k-1];
            nacc[k] = acc[k-1];
        end

        for (int k = 0; k < S; k++) begin
            s0[k]  = {1'b0, sa[k]} + {1'b0, sb[k]};
            s1[k]  = {1'b0, sa[k]} + {1'b0, sb[k]} + {{B{1'b0}}, 1'b1};
            sel[k] = scin[k] ? s1[k] : s0[k];
            // true carry into the slice MSB recovered from operands and sum bit
            sov[k] = (sa[k][B-1] ^ sb[k][B-1] ^ sel[k][B-1]) ^ sel[k][B];
            nacc[k][k*B +: B] = sel[k][B-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < S; k++) begin
                vld[k] <= 1'b0;
                acc[k] <= '0;
                cy[k]  <= 1'b0;
                xs[k]  <= '0;
                ys[k]  <= '0;
            end
            ovf <= 1'b0;
        end else if (adv) begin
            vld[0] <= in_valid;
            xs[0]  <= x;
            ys[0]  <= yeff;
            for (int k = 1; k < S; k++) begin
                vld[k] <= vld[k-1];
                xs[k]  <= xs[k-1];
                ys[k]  <= ys[k-1];
            end
            for (int k = 0; k < S; k++) begin
                acc[k] <= nacc[k];
                cy[k]  <= sel[k][B];
            end
            ovf <= sov[S-1];
        end
    end

`ifdef CSEL_ADDER_PIPE_SAT_EN
    // On overflow the wrapped MSB is the inverse of the true sign.
    assign sum = ovf ? (acc[S-1][N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}})
                     : acc[S-1];
`else
    assign sum = acc[S-1];
`endif

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed and streaming checks for csel_adder_pipe (N=32, B=8).
// Honours CSEL_ADDER_PIPE_SAT_EN when computing expected sums.
module tb_csel_adder_pipe;

    localparam int N = 32;
    localparam int B = 8;
    localparam int S = N / B;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         carryin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carryout;
    logic         overflow;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    csel_adder_pipe #(.N(N), .B(B)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .carryin(carryin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carryout(carryout), .overflow(overflow)
    );

    // Reference: {overflow, carryout, sum}, overflow from operand/result signs.
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic ci, input logic sb);
        logic [N-1:0] ye;
        logic         c0;
        logic [N:0]   t;
        logic         ov;
        logic [N-1:0] s;
        ye = sb ? ~b : b;
        c0 = sb ? 1'b1 : ci;
        t  = {1'b0, a} + {1'b0, ye} + {{N{1'b0}}, c0};
        ov = (a[N-1] == ye[N-1]) && (t[N-1] != a[N-1]);
        s  = t[N-1:0];
`ifdef CSEL_ADDER_PIPE_SAT_EN
        if (ov) s = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
        return {ov, t[N], s};
    endfunction

    task automatic send_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                            input logic sb, output logic [N-1:0] rs, output logic rco,
                            output logic rov, output int lat);
        rs = '0; rco = 1'b0; rov = 1'b0; lat = 0;
        @(negedge clk);
        x = a; y = b; carryin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i; rs = sum; rco = carryout; rov = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== '0) begin fails++; $display("[TB] FAIL reset_sum: got %h expected 0", sum); end
        checks++; if (carryout !== 1'b0) begin fails++; $display("[TB] FAIL reset_carryout: got %b expected 0", carryout); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add_basic();
        logic [N-1:0] rs; logic rco, rov; int lat;
        send_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, rs, rco, rov, lat);
        checks++; if (lat != S) begin fails++; $display("[TB] FAIL add_latency: got %0d expected %0d", lat, S); end
        checks++; if (rs !== 32'h0000_0100) begin fails++; $display("[TB] FAIL add_sum: got %h expected 00000100", rs); end
        checks++; if (rco !== 1'b0) begin fails++; $display("[TB] FAIL add_carryout: got %b expected 0", rco); end
        checks++; if (rov !== 1'b0) begin fails++; $display("[TB] FAIL add_overflow: got %b expected 0", rov); end
    endtask

    task automatic test_ripple();
        logic [N-1:0] rs; logic rco, rov; int lat;
        send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rco, rov, lat);
        checks++; if (lat != S) begin fails++; $display("[TB] FAIL ripple_latency: got %0d expected %0d", lat, S); end
        checks++; if (rs !== 32'h0000_0000) begin fails++; $display("[TB] FAIL ripple_sum: got %h expected 00000000", rs); end
        checks++; if (rco !== 1'b1) begin fails++; $display("[TB] FAIL ripple_carryout: got %b expected 1", rco); end
        checks++; if (rov !== 1'b0) begin fails++; $display("[TB] FAIL ripple_overflow: got %b expected 0", rov); end
    endtask

    task automatic test_overflow();
        logic [N-1:0] rs; logic rco, rov; int lat;
        logic [N-1:0] epos, eneg;
`ifdef CSEL_ADDER_PIPE_SAT_EN
        epos = 32'h7FFF_FFFF; eneg = 32'h8000_0000;
`else
        epos = 32'h8000_0000; eneg = 32'h7FFF_FFFF;
`endif
        send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rco, rov, lat);
        checks++; if (rs !== epos) begin fails++; $display("[TB] FAIL ovf_pos_sum: got %h expected %h", rs, epos); end
        checks++; if (rco !== 1'b0) begin fails++; $display("[TB] FAIL ovf_pos_carryout: got %b expected 0", rco); end
        checks++; if (rov !== 1'b1) begin fails++; $display("[TB] FAIL ovf_pos_overflow: got %b expected 1", rov); end
        send_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, rs, rco, rov, lat);
        checks++; if (rs !== eneg) begin fails++; $display("[TB] FAIL ovf_neg_sum: got %h expected %h", rs, eneg); end
        checks++; if (rco !== 1'b1) begin fails++; $display("[TB] FAIL ovf_neg_carryout: got %b expected 1", rco); end
        checks++; if (rov !== 1'b1) begin fails++; $display("[TB] FAIL ovf_neg_overflow: got %b expected 1", rov); end
    endtask

    task automatic test_sub_and_carryin();
        logic [N-1:0] rs; logic rco, rov; int lat;
        // carryin=1 must be ignored in subtract mode
        send_one(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, rs, rco, rov, lat);
        checks++; if (rs !== 32'hFFFF_FFFE) begin fails++; $display("[TB] FAIL sub_sum: got %h expected fffffffe", rs); end
        checks++; if (rco !== 1'b0) begin fails++; $display("[TB] FAIL sub_carryout: got %b expected 0", rco); end
        checks++; if (rov !== 1'b0) begin fails++; $display("[TB] FAIL sub_overflow: got %b expected 0", rov); end
        send_one(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, rs, rco, rov, lat);
        checks++; if (rs !== 32'h0000_0031) begin fails++; $display("[TB] FAIL cin_sum: got %h expected 00000031", rs); end
        checks++; if (rco !== 1'b0) begin fails++; $display("[TB] FAIL cin_carryout: got %b expected 0", rco); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ex [16];
        logic [N-1:0] ey [16];
        logic         ec [16];
        logic         es [16];
        logic [N+1:0] exp_r [16];
        int sent = 0, recv = 0, first = -1, last = -1, extra = 0;
        for (int i = 0; i < 16; i++) begin
            ex[i] = $urandom; ey[i] = $urandom; ec[i] = 1'($urandom_range(0, 1)); es[i] = 1'($urandom_range(0, 1));
            exp_r[i] = model(ex[i], ey[i], ec[i], es[i]);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && recv < 16; cyc++) begin
            @(negedge clk);
            if (sent < 16) begin
                in_valid = 1'b1; x = ex[sent]; y = ey[sent]; carryin = ec[sent]; sub = es[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                checks++;
                if ({overflow, carryout, sum} !== exp_r[recv]) begin
                    fails++;
                    $display("[TB] FAIL b2b_beat%0d: got %h expected %h", recv, {overflow, carryout, sum}, exp_r[recv]);
                end
                if (first < 0) first = cyc;
                last = cyc;
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (recv != 16) begin fails++; $display("[TB] FAIL b2b_count: got %0d expected 16", recv); end
        checks++; if (last - first != 15) begin fails++; $display("[TB] FAIL b2b_rate: got span %0d expected 15", last - first); end
        checks++; if (extra != 0) begin fails++; $display("[TB] FAIL b2b_extra: got %0d expected 0", extra); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] ex [16];
        logic [N-1:0] ey [16];
        logic         ec [16];
        logic         es [16];
        logic [N+1:0] exp_r [16];
        logic [N+1:0] held = '0;
        logic         prev_stall = 1'b0;
        int sent = 0, recv = 0, stalls = 0, extra = 0;
        for (int i = 0; i < 16; i++) begin
            ex[i] = $urandom; ey[i] = $urandom; ec[i] = 1'($urandom_range(0, 1)); es[i] = 1'($urandom_range(0, 1));
            exp_r[i] = model(ex[i], ey[i], ec[i], es[i]);
        end
        for (int cyc = 0; cyc < 80 && recv < 16; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc < 9);
            if (sent < 16) begin
                in_valid = 1'b1; x = ex[sent]; y = ey[sent]; carryin = ec[sent]; sub = es[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready); end
                if (prev_stall) begin
                    checks++;
                    if ({overflow, carryout, sum} !== held) begin
                        fails++;
                        $display("[TB] FAIL bp_stable: got %h expected %h", {overflow, carryout, sum}, held);
                    end
                end
                held = {overflow, carryout, sum};
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({overflow, carryout, sum} !== exp_r[recv]) begin
                    fails++;
                    $display("[TB] FAIL bp_beat%0d: got %h expected %h", recv, {overflow, carryout, sum}, exp_r[recv]);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++; if (stalls != 3) begin fails++; $display("[TB] FAIL bp_stall_cycles: got %0d expected 3", stalls); end
        checks++; if (recv != 16) begin fails++; $display("[TB] FAIL bp_count: got %0d expected 16", recv); end
        checks++; if (extra != 0) begin fails++; $display("[TB] FAIL bp_extra: got %0d expected 0", extra); end
    endtask

    task automatic test_async_reset();
        logic seen = 1'b0;
        int stale = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; x = 32'hFFFF_FFFF; y = 32'h8000_0000 + i; carryin = 1'b0; sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL rst_pre_valid: got %b expected 1", seen); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_async_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== '0) begin fails++; $display("[TB] FAIL rst_async_sum: got %h expected 0", sum); end
        checks++; if (carryout !== 1'b0) begin fails++; $display("[TB] FAIL rst_async_carryout: got %b expected 0", carryout); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL rst_async_overflow: got %b expected 0", overflow); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_release_in_ready: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale != 0) begin fails++; $display("[TB] FAIL rst_stale_beats: got %0d expected 0", stale); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; carryin = 1'b0; sub = 1'b0;
        test_reset();
        test_add_basic();
        test_ripple();
        test_overflow();
        test_sub_and_carryin();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
